commit_trace_fifo: RTL and testbench

- Synthesizable commit-event serializer for the N-lane pipeline.
- Each cycle it takes the per-lane writeback records and at most one data-bus store, orders them canonically, and pushes them into a multi-write FIFO.
- One record per cycle drains through a valid/ready port, each stamped with its commit cycle.
- Feeds the trace checker and on-board debug UART; replaces per-cycle event sampling in the CPU bench with an N-lane, depth-parametrised block.

---
 rtl/cpu_trace_pkg.sv | 24 ++
 rtl/trace_event_pack.sv | 76 +++++++
 rtl/commit_trace_fifo.sv | 177 +++++++++++++++++
 tb/tb_commit_trace_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the commit-trace path: record layout,
// record kind encoding and a helper for the store-lane select width.
package cpu_trace_pkg;

    localparam int TRACE_IDX_W   = 16;
    localparam int TRACE_STAMP_W = 32;

    localparam logic TRACE_KIND_REG = 1'b0;
    localparam logic TRACE_KIND_MEM = 1'b1;

    // One drained trace record as seen by the consumer.
    typedef struct packed {
        logic                     kind;
        logic [TRACE_IDX_W-1:0]   idx;
        logic [31:0]              data;
        logic [TRACE_STAMP_W-1:0] stamp;
    } trace_rec_t;

    // Width of a lane number; a single-lane pipeline still gets one bit.
    function automatic int lane_sel_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/trace_event_pack.sv
// Orders one cycle's commit events canonically (per lane: store, then
// register write) and packs them contiguously into slots 0..ev_cnt-1.
module trace_event_pack
    import cpu_trace_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int ADDR_W  = 16,
    parameter int LANE_W  = lane_sel_w(N_LANES),
    parameter int EV_W    = $clog2(N_LANES + 2)
) (
    input  logic                          capture,
    input  logic [N_LANES*5-1:0]          wb_rd,
    input  logic [N_LANES*32-1:0]         wb_data,
    input  logic                          st_valid,
    input  logic [LANE_W-1:0]             st_lane,
    input  logic [ADDR_W-1:0]             st_addr,
    input  logic [31:0]                   st_data,
    output logic [N_LANES:0]              ev_kind,
    output logic [N_LANES:0][ADDR_W-1:0]  ev_idx,
    output logic [N_LANES:0][31:0]        ev_data,
    output logic [EV_W-1:0]               ev_cnt
);

    // One extra bit so N_LANES itself is representable for the range check.
    localparam logic [LANE_W:0]   LANE_LIMIT = (LANE_W + 1)'(N_LANES);
    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(N_LANES - 1);

    logic [LANE_W-1:0]  st_lane_eff;
    logic [N_LANES-1:0] st_hit;
    logic [N_LANES-1:0] wb_hit;
    logic [ADDR_W-1:0]  st_idx;

    // Out-of-range store lanes fold onto the last lane.
    always_comb begin
        st_lane_eff = st_lane;
        if ({1'b0, st_lane} >= LANE_LIMIT) begin
            st_lane_eff = LANE_LAST;
        end
    end

    // Records carry the word-aligned address.
    assign st_idx = st_addr & ~ADDR_W'(3);

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign st_hit[gi] = capture & st_valid & (st_lane_eff == LANE_W'(gi));
            assign wb_hit[gi] = capture & (wb_rd[gi*5 +: 5] != 5'd0);
        end
    endgenerate

    // Walk lanes in order, appending each present event at the next free slot.
    always_comb begin
        int n;
        n       = 0;
        ev_kind = '0;
        ev_idx  = '0;
        ev_data = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (st_hit[i]) begin
                ev_kind[n] = TRACE_KIND_MEM;
                ev_idx[n]  = st_idx;
                ev_data[n] = st_data;
                n          = n + 1;
            end
            if (wb_hit[i]) begin
                ev_kind[n] = TRACE_KIND_REG;
                ev_idx[n]  = ADDR_W'(wb_rd[i*5 +: 5]);
                ev_data[n] = wb_data[i*32 +: 32];
                n          = n + 1;
            end
        end
        ev_cnt = EV_W'(n);
    end

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit-event serializer: captures up to N_LANES+1 events per cycle into a
// multi-write FIFO (all-or-nothing per cycle) and drains one stamped record
// per cycle through a registered valid/ready head.
module commit_trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 16,
    parameter int STAMP_W = 32,
    localparam int LANE_W = lane_sel_w(N_LANES),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trace_en,
    input  logic                  stall,
    input  logic [N_LANES*5-1:0]  wb_rd,
    input  logic [N_LANES*32-1:0] wb_data,
    input  logic                  st_valid,
    input  logic [LANE_W-1:0]     st_lane,
    input  logic [ADDR_W-1:0]     st_addr,
    input  logic [31:0]           st_data,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic                  rec_kind,
    output logic [ADDR_W-1:0]     rec_idx,
    output logic [31:0]           rec_data,
    output logic [STAMP_W-1:0]    rec_stamp,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int EV_W  = $clog2(N_LANES + 2);

    logic [N_LANES:0]             ev_kind;
    logic [N_LANES:0][ADDR_W-1:0] ev_idx;
    logic [N_LANES:0][31:0]       ev_data;
    logic [EV_W-1:0]              ev_cnt;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    logic               mem_kind_q  [DEPTH];
    logic               mem_kind_d  [DEPTH];
    logic [ADDR_W-1:0]  mem_idx_q   [DEPTH];
    logic [ADDR_W-1:0]  mem_idx_d   [DEPTH];
    logic [31:0]        mem_data_q  [DEPTH];
    logic [31:0]        mem_data_d  [DEPTH];
    logic [STAMP_W-1:0] mem_stamp_q [DEPTH];
    logic [STAMP_W-1:0] mem_stamp_d [DEPTH];

    logic               head_kind_q, head_kind_d;
    logic [ADDR_W-1:0]  head_idx_q, head_idx_d;
    logic [31:0]        head_data_q, head_data_d;
    logic [STAMP_W-1:0] head_stamp_q, head_stamp_d;

    logic               pop;
    logic               push_ok;
    logic [CNT_W:0]     free_slots;

    trace_event_pack #(
        .N_LANES (N_LANES),
        .ADDR_W  (ADDR_W),
        .LANE_W  (LANE_W),
        .EV_W    (EV_W)
    ) u_pack (
        .capture  (trace_en & ~stall),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .st_valid (st_valid),
        .st_lane  (st_lane),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .ev_kind  (ev_kind),
        .ev_idx   (ev_idx),
        .ev_data  (ev_data),
        .ev_cnt   (ev_cnt)
    );

    // Admission, storage writes, pointer/count update and next head selection.
    always_comb begin
        pop        = (count_q != '0) & rec_ready;
        // A pop this cycle frees its slot for this cycle's events.
        free_slots = (CNT_W + 1)'(DEPTH) - {1'b0, count_q} + (CNT_W + 1)'(pop);
        push_ok    = ((CNT_W + 1)'(ev_cnt) <= free_slots);

        // Records of this cycle carry the stamp the counter reaches at this edge.
        stamp_d = stamp_q + 1'b1;

        mem_kind_d  = mem_kind_q;
        mem_idx_d   = mem_idx_q;
        mem_data_d  = mem_data_q;
        mem_stamp_d = mem_stamp_q;
        for (int k = 0; k <= N_LANES; k++) begin
            if (push_ok && (EV_W'(k) < ev_cnt)) begin
                mem_kind_d[wr_ptr_q + PTR_W'(k)]  = ev_kind[k];
                mem_idx_d[wr_ptr_q + PTR_W'(k)]   = ev_idx[k];
                mem_data_d[wr_ptr_q + PTR_W'(k)]  = ev_data[k];
                mem_stamp_d[wr_ptr_q + PTR_W'(k)] = stamp_d;
            end
        end

        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_W'(ev_cnt)) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (push_ok ? CNT_W'(ev_cnt) : '0) - CNT_W'(pop);

        // A rejected cycle is dropped whole; the counter saturates.
        overflow_d = overflow_q | ~push_ok;
        drop_cnt_d = drop_cnt_q;
        if (!push_ok && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        // Head reads post-write storage so a freshly pushed entry shows next cycle.
        head_kind_d  = 1'b0;
        head_idx_d   = '0;
        head_data_d  = '0;
        head_stamp_d = '0;
        if (count_d != '0) begin
            head_kind_d  = mem_kind_d[rd_ptr_d];
            head_idx_d   = mem_idx_d[rd_ptr_d];
            head_data_d  = mem_data_d[rd_ptr_d];
            head_stamp_d = mem_stamp_d[rd_ptr_d];
        end
    end

    // Control state and registered head, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            stamp_q      <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            head_kind_q  <= 1'b0;
            head_idx_q   <= '0;
            head_data_q  <= '0;
            head_stamp_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            stamp_q      <= stamp_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            head_kind_q  <= head_kind_d;
            head_idx_q   <= head_idx_d;
            head_data_q  <= head_data_d;
            head_stamp_q <= head_stamp_d;
        end
    end

    // Entry storage needs no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        mem_kind_q  <= mem_kind_d;
        mem_idx_q   <= mem_idx_d;
        mem_data_q  <= mem_data_d;
        mem_stamp_q <= mem_stamp_d;
    end

    assign rec_valid = (count_q != '0);
    assign rec_kind  = head_kind_q;
    assign rec_idx   = head_idx_q;
    assign rec_data  = head_data_q;
    assign rec_stamp = head_stamp_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo (2 lanes, 4-deep) with a queue model
// of the expected record stream, checked after every clock edge.
module tb_commit_trace_fifo;
    import cpu_trace_pkg::*;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int AW = 16;
    localparam int SW = 32;

    logic            clk = 1'b0;
    logic            rst_n, trace_en, stall, st_valid, rec_ready;
    logic [N*5-1:0]  wb_rd;
    logic [N*32-1:0] wb_data;
    logic [0:0]      st_lane;
    logic [AW-1:0]   st_addr;
    logic [31:0]     st_data;
    logic            rec_valid, rec_kind, overflow;
    logic [AW-1:0]   rec_idx;
    logic [31:0]     rec_data;
    logic [SW-1:0]   rec_stamp;
    logic [2:0]      count;
    logic [15:0]     drop_cnt;

    int errors = 0;
    int checks = 0;

    trace_rec_t    exp_q[$];
    logic [SW-1:0] m_stamp;
    logic          m_ovf;
    int            m_drop;

    always #5 clk = ~clk;

    commit_trace_fifo #(
        .N_LANES (N),
        .DEPTH   (D),
        .ADDR_W  (AW),
        .STAMP_W (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trace_en  (trace_en),
        .stall     (stall),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .st_valid  (st_valid),
        .st_lane   (st_lane),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_kind  (rec_kind),
        .rec_idx   (rec_idx),
        .rec_data  (rec_data),
        .rec_stamp (rec_stamp),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply the effect of the coming clock edge to the model.
    task automatic model_step();
        trace_rec_t ev[$];
        trace_rec_t r;
        int         lane_eff;
        int         free;
        bit         pop;
        if (!rst_n) begin
            exp_q.delete();
            m_stamp = '0;
            m_ovf   = 1'b0;
            m_drop  = 0;
            return;
        end
        m_stamp  = m_stamp + 1;
        lane_eff = (int'(st_lane) >= N) ? N - 1 : int'(st_lane);
        if (trace_en && !stall) begin
            for (int i = 0; i < N; i++) begin
                if (st_valid && lane_eff == i) begin
                    r.kind = TRACE_KIND_MEM; r.idx = st_addr & 16'hFFFC;
                    r.data = st_data;        r.stamp = m_stamp;
                    ev.push_back(r);
                end
                if (wb_rd[i*5 +: 5] != 5'd0) begin
                    r.kind = TRACE_KIND_REG; r.idx = {11'd0, wb_rd[i*5 +: 5]};
                    r.data = wb_data[i*32 +: 32]; r.stamp = m_stamp;
                    ev.push_back(r);
                end
            end
        end
        pop  = (exp_q.size() != 0) && rec_ready;
        free = D - exp_q.size() + (pop ? 1 : 0);
        if (pop) void'(exp_q.pop_front());
        if (ev.size() > free) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end else begin
            foreach (ev[j]) exp_q.push_back(ev[j]);
        end
    endtask

    task automatic compare_outputs();
        chk("count", count, exp_q.size());
        chk("rec_valid", rec_valid, exp_q.size() != 0);
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
        if (exp_q.size() != 0) begin
            chk("rec_kind", rec_kind, exp_q[0].kind);
            chk("rec_idx", rec_idx, exp_q[0].idx);
            chk("rec_data", rec_data, exp_q[0].data);
            chk("rec_stamp", rec_stamp, exp_q[0].stamp);
        end
        $display("t=%0t rst_n=%0b cnt=%0d valid=%0b kind=%0b idx=0x%0h data=0x%0h stamp=%0d ovf=%0b drop=%0d",
                 $time, rst_n, count, rec_valid, rec_kind, rec_idx, rec_data, rec_stamp, overflow, drop_cnt);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic set_idle();
        trace_en = 1'b1; stall = 1'b0;
        wb_rd = '0; wb_data = '0;
        st_valid = 1'b0; st_lane = '0; st_addr = '0; st_data = '0;
    endtask

    initial begin
        rst_n = 1'b0; rec_ready = 1'b0;
        set_idle();
        cycle(); cycle();
        chk("rst_kind", rec_kind, 0);
        chk("rst_idx", rec_idx, 0);
        chk("rst_data", rec_data, 0);
        chk("rst_stamp", rec_stamp, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;

        // Two register writes, no store.
        rec_ready = 1'b1;
        wb_rd = {5'd5, 5'd3}; wb_data = {32'h2222_0000, 32'h1111_0000};
        cycle();
        chk("t1_idx0", rec_idx, 3);
        chk("t1_data0", rec_data, 32'h1111_0000);
        chk("t1_stamp0", rec_stamp, 1);
        set_idle(); cycle();
        chk("t1_idx1", rec_idx, 5);
        chk("t1_data1", rec_data, 32'h2222_0000);
        chk("t1_stamp1", rec_stamp, 1);
        cycle();

        // Store on lane 0 precedes both register writes.
        st_valid = 1'b1; st_lane = 1'b0; st_addr = 16'h0106; st_data = 32'hDEAD_BEEF;
        wb_rd = {5'd4, 5'd2}; wb_data = {32'h0000_00B0, 32'h0000_00A0};
        cycle();
        chk("t2_kind0", rec_kind, 1);
        chk("t2_idx0", rec_idx, 16'h0104);
        chk("t2_data0", rec_data, 32'hDEAD_BEEF);
        set_idle(); cycle();
        chk("t2_idx1", rec_idx, 2);
        cycle(); cycle();

        // Store on lane 1 sits between the two register writes.
        st_valid = 1'b1; st_lane = 1'b1; st_addr = 16'h0106; st_data = 32'hDEAD_BEEF;
        wb_rd = {5'd4, 5'd2}; wb_data = {32'h0000_00B0, 32'h0000_00A0};
        cycle();
        chk("t2b_kind0", rec_kind, 0);
        chk("t2b_idx0", rec_idx, 2);
        set_idle(); cycle();
        chk("t2b_kind1", rec_kind, 1);
        cycle(); cycle();

        // Stalled cycles capture nothing but the stamp keeps running.
        wb_rd = {5'd0, 5'd7}; wb_data = {32'd0, 32'h77};
        cycle();
        chk("t3_stamp_before", rec_stamp, 12);
        stall = 1'b1; st_valid = 1'b1; wb_rd = {5'd6, 5'd7};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_stall_count", count, 0);
        end
        stall = 1'b0; st_valid = 1'b0; wb_rd = {5'd0, 5'd7};
        cycle();
        chk("t3_stamp_after", rec_stamp, 18);
        set_idle(); cycle();

        // Overflow: a 2-event cycle cannot fit behind 3 held entries.
        rec_ready = 1'b0;
        st_valid = 1'b1; st_lane = 1'b0; st_addr = 16'h0020; st_data = 32'h55;
        wb_rd = {5'd1, 5'd8}; wb_data = {32'h11, 32'h88};
        cycle();
        chk("t4_count3", count, 3);
        set_idle(); wb_rd = {5'd12, 5'd13};
        cycle();
        chk("t4_count_drop", count, 3);
        chk("t4_overflow", overflow, 1);
        chk("t4_drop_cnt", drop_cnt, 1);
        wb_rd = {5'd0, 5'd9};
        cycle();
        chk("t4_count_full", count, 4);

        // Full FIFO with a pop accepts one more event.
        rec_ready = 1'b1; wb_rd = {5'd10, 5'd0};
        cycle();
        chk("t5_count", count, 4);
        chk("t5_kind", rec_kind, 0);
        chk("t5_idx", rec_idx, 8);

        // Reset mid-stream.
        set_idle(); cycle();
        chk("t6_count_pre", count, 3);
        rec_ready = 1'b0; rst_n = 1'b0; wb_rd = {5'd0, 5'd11};
        cycle();
        chk("t6_count", count, 0);
        chk("t6_valid", rec_valid, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_drop", drop_cnt, 0);
        rst_n = 1'b1;
        cycle();
        chk("t6_stamp", rec_stamp, 1);
        chk("t6_idx", rec_idx, 11);
        rec_ready = 1'b1; set_idle();
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
